// File: rtl/pxs_sync_gen_if.sv
// -----------------------------------------------------------------------------
// pxs_sync_gen_if
// Groups the pixel-stream source signals of pxs_sync_gen.
//   en_i      : pixel advance enable (consumer -> generator)
//   rgb_bg_i  : background colour {B,G,R} (consumer -> generator)
//   RGBStr_o  : 26-bit stream [0] Active, [1] VS, [2] HS, [12:3] YC,
//               [22:13] XC, [23] R, [24] G, [25] B
//   frame_o   : start-of-frame pulse, aligned with the XC=0/YC=0 beat
//   blink_o   : frame-based blink phase
// Modports: master = the generator, slave = the stream consumer.
// -----------------------------------------------------------------------------
interface pxs_sync_gen_if;
  logic        en_i;
  logic [2:0]  rgb_bg_i;
  logic [25:0] RGBStr_o;
  logic        frame_o;
  logic        blink_o;

  modport master (
    input  en_i,
    input  rgb_bg_i,
    output RGBStr_o,
    output frame_o,
    output blink_o
  );

  modport slave (
    output en_i,
    output rgb_bg_i,
    input  RGBStr_o,
    input  frame_o,
    input  blink_o
  );
endinterface

// File: rtl/pxs_sync_gen.sv
// -----------------------------------------------------------------------------
// pxs_sync_gen
// Source end of the 26-bit pixel stream. Runs the horizontal/vertical
// counters and packs coordinates, sync levels, the active flag and the
// background colour into a registered stream beat, one beat behind the
// counters. Also produces a start-of-frame pulse and a blink phase.
//
// Ports:
//   px_clk  : pixel clock
//   rst_n   : asynchronous, active-low reset
//   bus     : pxs_sync_gen_if.master (en_i, rgb_bg_i, RGBStr_o, frame_o,
//             blink_o)
//
// Optional feature macro: PXS_SYNC_BLINK_EN
//   defined   -> frame counter of BLINK_FRAMES frames drives blink_o
//   undefined -> blink_o is tied low, BLINK_FRAMES has no effect
// -----------------------------------------------------------------------------
module pxs_sync_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           px_clk,
  input  logic           rst_n,
  pxs_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // All timing thresholds as 10-bit constants so compares stay width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  // Idle stream: everything zero except both syncs at their inactive level.
  localparam logic [25:0] STR_RESET = {23'd0, ~HS_POL, ~VS_POL, 1'b0};

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [25:0] r_str;
  logic        r_frame;

  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic [2:0]  w_rgb;
  logic        w_frame;
  logic [25:0] w_str;

  // Raster counters: hc runs across the line, vc advances on each line wrap.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (bus.en_i) begin
      if (r_hc == H_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Next stream beat decoded from the current counter values.
  always_comb begin
    w_active = (r_hc < H_ACT_END) && (r_vc < V_ACT_END);
    w_hs     = ((r_hc >= HS_START) && (r_hc < HS_END)) ? HS_POL : ~HS_POL;
    w_vs     = ((r_vc >= VS_START) && (r_vc < VS_END)) ? VS_POL : ~VS_POL;
    w_rgb    = w_active ? bus.rgb_bg_i : 3'b000;
    w_frame  = (r_hc == 10'd0) && (r_vc == 10'd0);
    w_str    = {w_rgb, r_hc, r_vc, w_hs, w_vs, w_active};
  end

  // Output register: the stream and frame pulse lag the counters by one beat
  // and freeze together with them when en_i is low.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_str   <= STR_RESET;
      r_frame <= 1'b0;
    end else if (bus.en_i) begin
      r_str   <= w_str;
      r_frame <= w_frame;
    end
  end

  assign bus.RGBStr_o = r_str;
  assign bus.frame_o  = r_frame;

`ifdef PXS_SYNC_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] r_fcnt;
  logic            r_blink;

  // Counts frame beats; toggling on the terminal beat lines the blink edge up
  // with the frame_o beat that ends the half-period.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_blink <= 1'b0;
    end else if (bus.en_i && w_frame) begin
      if (r_fcnt == FC_LAST) begin
        r_fcnt  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fcnt <= r_fcnt + FC_W'(1);
      end
    end
  end

  assign bus.blink_o = r_blink;
`else
  // Without the blink feature the phase is a constant low.
  localparam logic BLINK_IDLE = (BLINK_FRAMES >= 1) ? 1'b0 : 1'b0;

  assign bus.blink_o = BLINK_IDLE;
`endif

endmodule
